// File: rtl/bubsys_rom_slot_arbiter_pkg.sv
// ============================================================================
// bubsys_rom_slot_arbiter_pkg : shared types and constants for the ROM arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package bubsys_rom_slot_arbiter_pkg;

  localparam int SDRAM_AW = 22;
  localparam int DW       = 16;

  // Bank 0 layout: game program at the bottom, bootloader above it.
  localparam logic [SDRAM_AW-1:0] GAME_OFFSET = 22'h00_0000;
  localparam logic [SDRAM_AW-1:0] BOOT_OFFSET = 22'h02_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/bubsys_rom_slot_cache.sv
// ============================================================================
// bubsys_rom_slot_cache : one-word tagged read cache with combinational hit
// Rev 1.0
// ============================================================================
`default_nettype none

module bubsys_rom_slot_cache
  import bubsys_rom_slot_arbiter_pkg::*;
#(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_fill,
  input  logic [AW-1:0] i_fill_tag,
  input  logic [DW-1:0] i_fill_data,
  input  logic          i_cs,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] o_dout,
  output logic          o_ok
);

  logic          r_valid;
  logic [AW-1:0] r_tag;
  logic [DW-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_tag   <= i_fill_tag;
      r_data  <= i_fill_data;
    end
  end

  assign o_ok   = i_cs & r_valid & (r_tag == i_addr);
  assign o_dout = r_data;

endmodule

`default_nettype wire

// File: rtl/bubsys_rom_slot_arbiter.sv
// ============================================================================
// bubsys_rom_slot_arbiter : two cached ROM slots sharing the SDRAM bank 0 port
// Rev 1.0
// ============================================================================
`default_nettype none

module bubsys_rom_slot_arbiter
  import bubsys_rom_slot_arbiter_pkg::*;
#(
  parameter int                  SLOT0_AW     = 17,
  parameter int                  SLOT1_AW     = 15,
  parameter logic [SDRAM_AW-1:0] SLOT0_OFFSET = GAME_OFFSET,
  parameter logic [SDRAM_AW-1:0] SLOT1_OFFSET = BOOT_OFFSET,
  parameter logic [7:0]          TIMEOUT      = 8'd255
) (
  input  logic                i_EMU_MCLK,
  input  logic                i_EMU_INITRST,
  input  logic                i_EN,
  input  logic                i_SLOT0_CS,
  input  logic [SLOT0_AW-1:0] i_SLOT0_ADDR,
  output logic [DW-1:0]       o_SLOT0_DOUT,
  output logic                o_SLOT0_OK,
  input  logic                i_SLOT1_CS,
  input  logic [SLOT1_AW-1:0] i_SLOT1_ADDR,
  output logic [DW-1:0]       o_SLOT1_DOUT,
  output logic                o_SLOT1_OK,
  output logic [SDRAM_AW-1:0] o_SDRAM_ADDR,
  output logic                o_SDRAM_REQ,
  input  logic                i_SDRAM_ACK,
  input  logic                i_SDRAM_DST,
  input  logic                i_SDRAM_RDY,
  input  logic [DW-1:0]       i_SDRAM_DATA,
  output logic                o_BUSY
);

  // A low enable (download not finished) clears everything like a reset.
  logic w_rst;
  assign w_rst = i_EMU_INITRST | ~i_EN;

  arb_state_t          r_state, w_state_nxt;
  logic                r_req, w_req_nxt;
  logic [SDRAM_AW-1:0] r_addr, w_addr_nxt;
  logic                r_ptr, w_ptr_nxt;
  logic                r_grant, w_grant_nxt;
  logic [7:0]          r_wdog, w_wdog_nxt;
  logic                r_dst_seen, w_dst_seen_nxt;
  logic [SLOT0_AW-1:0] r_ptag0, w_ptag0_nxt;
  logic [SLOT1_AW-1:0] r_ptag1, w_ptag1_nxt;
  logic                w_fill0, w_fill1;
  logic                w_pick;
  logic                w_miss0, w_miss1;
  logic [SDRAM_AW-1:0] w_sdram0, w_sdram1;

  assign w_miss0  = i_SLOT0_CS & ~o_SLOT0_OK;
  assign w_miss1  = i_SLOT1_CS & ~o_SLOT1_OK;
  assign w_sdram0 = SLOT0_OFFSET + SDRAM_AW'(i_SLOT0_ADDR);
  assign w_sdram1 = SLOT1_OFFSET + SDRAM_AW'(i_SLOT1_ADDR);

  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_req;
    w_addr_nxt     = r_addr;
    w_ptr_nxt      = r_ptr;
    w_grant_nxt    = r_grant;
    w_wdog_nxt     = r_wdog;
    w_dst_seen_nxt = r_dst_seen;
    w_ptag0_nxt    = r_ptag0;
    w_ptag1_nxt    = r_ptag1;
    w_fill0        = 1'b0;
    w_fill1        = 1'b0;
    w_pick         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_miss0 | w_miss1) begin
          // Pointer only advances when both slots contend.
          if (w_miss0 & w_miss1) begin
            w_pick    = r_ptr;
            w_ptr_nxt = ~r_ptr;
          end else begin
            w_pick = w_miss1;
          end
          w_grant_nxt = w_pick;
          if (!w_pick) begin
            w_ptag0_nxt = i_SLOT0_ADDR;
            w_addr_nxt  = w_sdram0;
          end else begin
            w_ptag1_nxt = i_SLOT1_ADDR;
            w_addr_nxt  = w_sdram1;
          end
          w_req_nxt   = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        w_wdog_nxt     = '0;
        w_dst_seen_nxt = 1'b0;
        if (i_SDRAM_ACK) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        w_wdog_nxt = 8'(r_wdog + 8'd1);
        if (i_SDRAM_DST && !r_dst_seen) begin
          w_dst_seen_nxt = 1'b1;
          w_fill0        = ~r_grant;
          w_fill1        = r_grant;
        end
        if (i_SDRAM_RDY) begin
          w_state_nxt = IDLE;
        end else if ((TIMEOUT != 8'd0) && (w_wdog_nxt == TIMEOUT)) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (w_rst) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_ptr      <= 1'b0;
      r_grant    <= 1'b0;
      r_wdog     <= '0;
      r_dst_seen <= 1'b0;
      r_ptag0    <= '0;
      r_ptag1    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= w_req_nxt;
      r_addr     <= w_addr_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant    <= w_grant_nxt;
      r_wdog     <= w_wdog_nxt;
      r_dst_seen <= w_dst_seen_nxt;
      r_ptag0    <= w_ptag0_nxt;
      r_ptag1    <= w_ptag1_nxt;
    end
  end

  bubsys_rom_slot_cache #(.AW(SLOT0_AW)) u_cache0 (
    .clk         (i_EMU_MCLK),
    .rst         (w_rst),
    .i_fill      (w_fill0),
    .i_fill_tag  (r_ptag0),
    .i_fill_data (i_SDRAM_DATA),
    .i_cs        (i_SLOT0_CS),
    .i_addr      (i_SLOT0_ADDR),
    .o_dout      (o_SLOT0_DOUT),
    .o_ok        (o_SLOT0_OK)
  );

  bubsys_rom_slot_cache #(.AW(SLOT1_AW)) u_cache1 (
    .clk         (i_EMU_MCLK),
    .rst         (w_rst),
    .i_fill      (w_fill1),
    .i_fill_tag  (r_ptag1),
    .i_fill_data (i_SDRAM_DATA),
    .i_cs        (i_SLOT1_CS),
    .i_addr      (i_SLOT1_ADDR),
    .o_dout      (o_SLOT1_DOUT),
    .o_ok        (o_SLOT1_OK)
  );

  assign o_SDRAM_REQ  = r_req;
  assign o_SDRAM_ADDR = r_addr;
  assign o_BUSY       = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_bubsys_rom_slot_arbiter.sv
// ============================================================================
// tb_bubsys_rom_slot_arbiter : directed vectors plus corner-case sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bubsys_rom_slot_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        cs0 = 1'b0, cs1 = 1'b0;
  logic [16:0] addr0 = '0;
  logic [14:0] addr1 = '0;
  logic [15:0] dout0, dout1;
  logic        ok0, ok1;
  logic [21:0] sd_addr;
  logic        sd_req, busy;
  logic        ack = 1'b0, dst = 1'b0, rdy = 1'b0;
  logic [15:0] sd_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bubsys_rom_slot_arbiter #(.TIMEOUT(8'd8)) dut (
    .i_EMU_MCLK    (clk),
    .i_EMU_INITRST (rst),
    .i_EN          (en),
    .i_SLOT0_CS    (cs0),
    .i_SLOT0_ADDR  (addr0),
    .o_SLOT0_DOUT  (dout0),
    .o_SLOT0_OK    (ok0),
    .i_SLOT1_CS    (cs1),
    .i_SLOT1_ADDR  (addr1),
    .o_SLOT1_DOUT  (dout1),
    .o_SLOT1_OK    (ok1),
    .o_SDRAM_ADDR  (sd_addr),
    .o_SDRAM_REQ   (sd_req),
    .i_SDRAM_ACK   (ack),
    .i_SDRAM_DST   (dst),
    .i_SDRAM_RDY   (rdy),
    .i_SDRAM_DATA  (sd_data),
    .o_BUSY        (busy)
  );

  typedef struct {
    logic        sel;
    logic [16:0] addr;
    logic [15:0] data;
    logic [21:0] exp_sdram;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!sd_req && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_req_seen"}, 32'(sd_req), 32'd1);
  endtask

  // Serve one request: check its address, ack after ack_dly, DST+RDY after dst_dly.
  task automatic do_txn(input string name, input logic [21:0] exp_addr,
                        input logic [15:0] data, input int ack_dly, input int dst_dly);
    wait_req(name);
    chk({name, "_addr"}, 32'(sd_addr), 32'(exp_addr));
    chk({name, "_busy"}, 32'(busy), 32'd1);
    repeat (ack_dly) tick();
    chk({name, "_addr_hold"}, 32'(sd_addr), 32'(exp_addr));
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk({name, "_req_clr"}, 32'(sd_req), 32'd0);
    repeat (dst_dly) tick();
    dst = 1'b1; rdy = 1'b1; sd_data = data;
    tick();
    dst = 1'b0; rdy = 1'b0; sd_data = '0;
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{sel: 1'b0, addr: 17'h00010, data: 16'hA55A, exp_sdram: 22'h000010};
    vecs[1] = '{sel: 1'b0, addr: 17'h1FFFF, data: 16'h1234, exp_sdram: 22'h01FFFF};
    vecs[2] = '{sel: 1'b1, addr: 17'h07FFF, data: 16'hBEEF, exp_sdram: 22'h027FFF};
    vecs[3] = '{sel: 1'b1, addr: 17'h00000, data: 16'h0001, exp_sdram: 22'h020000};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_ok0", 32'(ok0), 0);
    chk("rst_ok1", 32'(ok1), 0);
    chk("rst_dout0", 32'(dout0), 0);
    chk("rst_dout1", 32'(dout1), 0);
    chk("rst_req", 32'(sd_req), 0);
    chk("rst_addr", 32'(sd_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    en = 1'b1;
    tick();

    // Single-slot fills from the vector table.
    for (int i = 0; i < 4; i++) begin
      if (!vecs[i].sel) begin cs0 = 1'b1; addr0 = vecs[i].addr; end
      else begin cs1 = 1'b1; addr1 = vecs[i].addr[14:0]; end
      do_txn($sformatf("vec%0d", i), vecs[i].exp_sdram, vecs[i].data, 2, 2);
      if (!vecs[i].sel) begin
        chk($sformatf("vec%0d_ok", i), 32'(ok0), 1);
        chk($sformatf("vec%0d_dout", i), 32'(dout0), 32'(vecs[i].data));
      end else begin
        chk($sformatf("vec%0d_ok", i), 32'(ok1), 1);
        chk($sformatf("vec%0d_dout", i), 32'(dout1), 32'(vecs[i].data));
      end
      chk($sformatf("vec%0d_busy_end", i), 32'(busy), 0);
      repeat (3) tick();
      chk($sformatf("vec%0d_no_rereq", i), 32'(sd_req), 0);
      cs0 = 1'b0; cs1 = 1'b0;
      tick();
    end

    // Round-robin between simultaneous misses.
    rst = 1'b1; tick(); rst = 1'b0;
    cs0 = 1'b1; addr0 = 17'h1; cs1 = 1'b1; addr1 = 15'h2;
    do_txn("rr_a", 22'h000001, 16'h1111, 1, 1);
    do_txn("rr_b", 22'h020002, 16'h2222, 1, 1);
    chk("rr_ok0", 32'(ok0), 1);
    chk("rr_ok1", 32'(ok1), 1);
    addr0 = 17'h3; addr1 = 15'h4;
    do_txn("rr_c", 22'h020004, 16'h4444, 1, 1);
    do_txn("rr_d", 22'h000003, 16'h3333, 1, 1);
    chk("rr_dout0", 32'(dout0), 32'h3333);
    chk("rr_dout1", 32'(dout1), 32'h4444);
    cs0 = 1'b0; cs1 = 1'b0;
    tick();

    // Slot 1 address changes after ACK.
    cs1 = 1'b1; addr1 = 15'h5;
    wait_req("chg");
    chk("chg_addr", 32'(sd_addr), 32'h020005);
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    addr1 = 15'h6;
    tick();
    dst = 1'b1; rdy = 1'b1; sd_data = 16'h5555;
    tick();
    dst = 1'b0; rdy = 1'b0; sd_data = '0;
    chk("chg_ok_low", 32'(ok1), 0);
    chk("chg_dout_old", 32'(dout1), 32'h5555);
    do_txn("chg2", 22'h020006, 16'h6666, 1, 1);
    chk("chg2_ok", 32'(ok1), 1);
    chk("chg2_dout", 32'(dout1), 32'h6666);
    cs1 = 1'b0;
    tick();

    // Enable dropped during WAIT; late DST must be ignored.
    cs0 = 1'b1; addr0 = 17'h20;
    wait_req("en");
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    en = 1'b0;
    tick(); tick();
    dst = 1'b1; rdy = 1'b1; sd_data = 16'hDEAD;
    tick();
    dst = 1'b0; rdy = 1'b0; sd_data = '0;
    chk("en_ok0", 32'(ok0), 0);
    chk("en_ok1", 32'(ok1), 0);
    chk("en_dout0", 32'(dout0), 0);
    chk("en_dout1", 32'(dout1), 0);
    chk("en_req", 32'(sd_req), 0);
    chk("en_busy", 32'(busy), 0);
    cs0 = 1'b0; en = 1'b1;
    tick();

    // Watchdog: ACK but no DST; 8 WAIT cycles, one IDLE, then a reissue.
    begin
      int n = 0;
      cs0 = 1'b1; addr0 = 17'h30;
      wait_req("to");
      chk("to_addr", 32'(sd_addr), 32'h000030);
      ack = 1'b1; tick(); ack = 1'b0;
      while (!sd_req && n < 30) begin
        tick();
        n++;
      end
      chk("to_reissue_cycles", 32'(n), 32'd9);
      chk("to_reissue_addr", 32'(sd_addr), 32'h000030);
      chk("to_ok0", 32'(ok0), 0);
      chk("to_dout0", 32'(dout0), 0);
      tick();
      ack = 1'b1; tick(); ack = 1'b0;
      dst = 1'b1; rdy = 1'b1; sd_data = 16'h3030;
      tick();
      dst = 1'b0; rdy = 1'b0; sd_data = '0;
      chk("to_fill_ok0", 32'(ok0), 1);
      chk("to_fill_dout0", 32'(dout0), 32'h3030);
      cs0 = 1'b0;
      tick();
    end

    // DST and RDY in separate cycles; a second DST must not recapture.
    cs0 = 1'b1; addr0 = 17'h40;
    wait_req("split");
    ack = 1'b1; tick(); ack = 1'b0;
    tick();
    dst = 1'b1; sd_data = 16'h4444;
    tick();
    dst = 1'b0; sd_data = '0;
    chk("split_ok0", 32'(ok0), 1);
    chk("split_dout0", 32'(dout0), 32'h4444);
    chk("split_busy_mid", 32'(busy), 1);
    dst = 1'b1; sd_data = 16'h9999;
    tick();
    dst = 1'b0; sd_data = '0;
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("split_busy_end", 32'(busy), 0);
    chk("split_dout_keep", 32'(dout0), 32'h4444);
    cs0 = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bubsys_rom_slot_arbiter.md
Name: bubsys_rom_slot_arbiter

Overview:
- Shares SDRAM bank 0 read port between two 16-bit ROM requesters: slot 0 is the game program, slot 1 is the bootloader.
- Each slot has a one-word cache. Misses are arbitrated round-robin and issued to the SDRAM controller with a req/ack/dst/rdy handshake.
- Sits between the game board ROM fetch ports and the SDRAM controller's bank 0 read channel.
- Gated by the download-done flag; replaces the generic two-slot ROM front end.

Parameters:
- SLOT0_AW, 17, slot 0 word-address width.
- SLOT1_AW, 15, slot 1 word-address width.
- SLOT0_OFFSET, 22'h00_0000, SDRAM word offset added to slot 0 address.
- SLOT1_OFFSET, 22'h02_0000, SDRAM word offset added to slot 1 address.
- TIMEOUT, 8'd255, cycles to wait for dst after ack before retry; 0 disables the watchdog.

Ports:
- i_EMU_MCLK  in  1  sole clock.
- i_EMU_INITRST  in  1  reset; synchronous, active-high.
- i_EN  in  1  ROM download complete; low acts as a soft reset.
- i_SLOT0_CS  in  1  slot 0 read request.
- i_SLOT0_ADDR  in  SLOT0_AW  slot 0 word address.
- o_SLOT0_DOUT  out  16  slot 0 cached data.
- o_SLOT0_OK  out  1  slot 0 data valid for the current address.
- i_SLOT1_CS, i_SLOT1_ADDR (SLOT1_AW), o_SLOT1_DOUT (16), o_SLOT1_OK: same as slot 0.
- o_SDRAM_ADDR  out  22  read word address.
- o_SDRAM_REQ  out  1  read request.
- i_SDRAM_ACK  in  1  request accepted (1-cycle pulse).
- i_SDRAM_DST  in  1  data strobe; i_SDRAM_DATA is valid this cycle.
- i_SDRAM_RDY  in  1  transfer complete (may coincide with DST).
- i_SDRAM_DATA  in  16  read data.
- o_BUSY  out  1  high whenever state is not IDLE.

Behaviour:
- Reset, or i_EN low (checked every cycle, same priority as reset):
  - state = IDLE, o_SDRAM_REQ = 0, o_SDRAM_ADDR = 0.
  - Both caches: valid = 0, tag = 0, data = 16'h0000, so DOUT = 0 and OK = 0.
  - Round-robin pointer = slot 0; watchdog = 0.
  - A transaction in flight is abandoned. Later DST/RDY pulses are ignored because state is not WAIT.
- Hit detection (combinational):
  - o_SLOTn_OK = i_SLOTn_CS & valid_n & (tag_n == i_SLOTn_ADDR).
  - o_SLOTn_DOUT is always the cache data register.
- A slot misses when its CS is high and it does not hit.
- States:
  - IDLE: if any slot misses, grant one and go to REQ.
    - Both miss: grant the slot the pointer selects, then set the pointer to the other slot.
    - One misses: grant it; pointer is unchanged.
    - On grant, latch the slot's address as the pending tag and register o_SDRAM_ADDR = SLOTn_OFFSET + zero-extended addr, modulo 2^22.
  - REQ: o_SDRAM_REQ = 1 with the address held stable. On i_SDRAM_ACK, clear REQ the next cycle and go to WAIT. Watchdog cleared.
  - WAIT: watchdog increments each cycle.
    - First DST: write i_SDRAM_DATA and the pending tag into the granted cache; set valid.
    - RDY (same cycle as DST or later): go to IDLE.
    - Watchdog reaches TIMEOUT (TIMEOUT != 0): go to IDLE without writing. The miss re-arbitrates.
- Latency:
  - Miss seen in cycle 0 → REQ high in cycle 1.
  - DST in cycle d → OK high in cycle d+1 if CS and address are unchanged.
  - Minimum hit-to-data latency is 0 cycles.
- Address changes mid-flight: data is stored under the latched tag. The new address misses and gets its own request after return to IDLE. No partial OK is ever asserted.
- CS drops mid-flight: the transaction completes and the cache is filled.
- DST outside WAIT is ignored. ACK outside REQ is ignored.
- Only one transaction is outstanding at any time.

Decomposition:
- Shared package holds:
  - state enum {IDLE, REQ, WAIT};
  - SDRAM_AW = 22 and DW = 16 constants;
  - default slot offsets for bank 0 (game 0x00_0000, boot 0x02_0000).
- One sub-module, bubsys_rom_slot_cache, instantiated twice. Parameterised by AW; contains tag, data, valid, the fill port and the combinational hit compare.

Test Plan:
- Reset, then i_EN=1; slot 0 CS with addr 17'h00010; controller acks at +3 and sends DST+RDY with 16'hA55A at +6 → REQ with o_SDRAM_ADDR 22'h000010; OK0 high next cycle, DOUT0 = 16'hA55A; re-read of the same address causes no new REQ.
- Slot 0 (addr 0x1) and slot 1 (addr 0x2) miss in the same cycle → slot 0 served first at 22'h000001, then slot 1 at 22'h020002; on the next simultaneous miss, slot 1 goes first.
- Slot 1 changes addr from 0x5 to 0x6 after ACK → cache tag 0x5 stored, OK1 stays low; a second REQ for 22'h020006 follows; OK1 rises only after its DST.
- i_EN dropped during WAIT, and a DST with 16'hDEAD arrives 2 cycles later → DST ignored; both OK outputs 0, both DOUT outputs 0, REQ 0, o_BUSY 0.
- TIMEOUT=8, ACK given but no DST → return to IDLE after 8 WAIT cycles; request reissued to the same address; cache untouched.
- DST and RDY in separate cycles (DST at +5, RDY at +7) → data captured at +5, o_BUSY falls after +7, no second capture.
